// File: rtl/mptr_pkg.sv
// Shared types and reset constants for the mptr_bank pointer bank.
package mptr_pkg;

  typedef enum logic [1:0] {
    MODE_POST = 2'b00,
    MODE_PRE  = 2'b01,
    MODE_HOLD = 2'b10,
    MODE_RSVD = 2'b11
  } mptr_mode_e;

  // Decoded winner of the per-cycle strobe priority chain.
  typedef enum logic [2:0] {
    OP_NONE,
    OP_WRITE,
    OP_WRITEU,
    OP_MODE,
    OP_BASE,
    OP_LIMIT,
    OP_READ
  } mptr_op_e;

  localparam int MPTR_MAX_W = 32;

  localparam mptr_mode_e MPTR_MODE_RST      = MODE_POST;
  localparam logic       MPTR_PTR_RST_BIT   = 1'b0;
  localparam logic       MPTR_BASE_RST_BIT  = 1'b0;
  localparam logic       MPTR_LIMIT_RST_BIT = 1'b1;

  typedef struct packed {
    logic [MPTR_MAX_W-1:0] next;
    logic                  wrap;
  } mptr_step_t;

endpackage

// File: rtl/mptr_bank_if.sv
// CPU-side strobe/bus bundle for mptr_bank; bound write ports exist only with MPTR_CIRC_EN.
interface mptr_bank_if #(
  parameter int WIDTH = 16,
  parameter int NPTR  = 4,
  parameter int OFFW  = 12
) ();

  logic [$clog2(NPTR)-1:0] sel;
  logic [WIDTH-1:0]        din;
  logic [OFFW-1:0]         offsetin;
  logic                    write;
  logic                    writeu;
  logic                    write_mode;
`ifdef MPTR_CIRC_EN
  logic                    write_base;
  logic                    write_limit;
`endif
  logic                    read_abus;
  logic                    read_dbus;
  logic [WIDTH-1:0]        abus_out;
  logic                    abus_valid;
  logic [WIDTH-1:0]        dbus_out;
  logic                    dbus_valid;
  logic                    wrap;

  modport master (
    output sel, din, offsetin, write, writeu, write_mode,
`ifdef MPTR_CIRC_EN
    output write_base, write_limit,
`endif
    output read_abus, read_dbus,
    input  abus_out, abus_valid, dbus_out, dbus_valid, wrap
  );

  modport slave (
    input  sel, din, offsetin, write, writeu, write_mode,
`ifdef MPTR_CIRC_EN
    input  write_base, write_limit,
`endif
    input  read_abus, read_dbus,
    output abus_out, abus_valid, dbus_out, dbus_valid, wrap
  );

endinterface

// File: rtl/mptr_step.sv
// Combinational pointer step: applies mode and signed offset, reports wrap.
// MPTR_CIRC_EN selects circular [base, limit] wrap instead of modulo-2^WIDTH.
module mptr_step
  import mptr_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] ptr_i,
  input  logic [WIDTH-1:0] off_i,
  input  mptr_mode_e       mode_i,
  input  logic [WIDTH-1:0] base_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic [WIDTH-1:0] next_o,
  output logic [WIDTH-1:0] addr_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] stepped;
  logic             step_wrap;
  mptr_step_t       res;

`ifdef MPTR_CIRC_EN
  // Three guard bits hold every intermediate, including the base > limit case.
  localparam int EW = WIDTH + 3;
  localparam logic signed [EW-1:0] ONE = EW'(1);

  logic signed [EW-1:0] t;
  logic signed [EW-1:0] b;
  logic signed [EW-1:0] l;
  logic signed [EW-1:0] span;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    b         = $signed({3'b000, base_i});
    l         = $signed({3'b000, limit_i});
    span      = l - b + ONE;
    t         = $signed({3'b000, ptr_i}) + $signed({{3{off_i[WIDTH-1]}}, off_i});
    step_wrap = 1'b0;
    if (t > l) begin
      t         = t - span;
      step_wrap = 1'b1;
    end else if (t < b) begin
      t         = t + span;
      step_wrap = 1'b1;
    end
    if (t > l || t < b) begin
      t         = b;
      step_wrap = 1'b1;
    end
    stepped = t[WIDTH-1:0];
  end
`else
  logic [WIDTH:0] sum;
  logic           unused_bounds;

  assign unused_bounds = ^{base_i, limit_i};
  assign sum           = {1'b0, ptr_i} + {1'b0, off_i};
  assign stepped       = sum[WIDTH-1:0];
  // Adding a negative offset borrows exactly when the two's-complement add does not carry.
  assign step_wrap     = (off_i != '0) && (off_i[WIDTH-1] ? ~sum[WIDTH] : sum[WIDTH]);
`endif

  always_comb begin
    res    = '0;
    addr_o = ptr_i;
    case (mode_i)
      MODE_POST: begin
        res.next = MPTR_MAX_W'(stepped);
        res.wrap = step_wrap;
      end
      MODE_PRE: begin
        res.next = MPTR_MAX_W'(stepped);
        res.wrap = step_wrap;
        addr_o   = stepped;
      end
      default: res.next = MPTR_MAX_W'(ptr_i);
    endcase
  end

  assign next_o = res.next[WIDTH-1:0];
  assign wrap_o = res.wrap;

  if (WIDTH < MPTR_MAX_W) begin : g_next_hi
    logic unused_next_hi;
    assign unused_next_hi = ^res.next[MPTR_MAX_W-1:WIDTH];
  end

endmodule

// File: rtl/mptr_bank.sv
// Bank of NPTR memory pointers with per-pointer POST/PRE/HOLD addressing and registered buses.
// Optional feature macro: MPTR_CIRC_EN adds per-pointer base/limit circular wrap.
module mptr_bank
  import mptr_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NPTR  = 4,
  parameter int OFFW  = 12
) (
  input logic       clk,
  input logic       reset,
  mptr_bank_if.slave bus
);

  logic [WIDTH-1:0] ptr_q  [NPTR];
  mptr_mode_e       mode_q [NPTR];
`ifdef MPTR_CIRC_EN
  logic [WIDTH-1:0] base_q  [NPTR];
  logic [WIDTH-1:0] limit_q [NPTR];
`endif

  logic [WIDTH-1:0] abus_q;
  logic             abus_valid_q;
  logic [WIDTH-1:0] dbus_q;
  logic             dbus_valid_q;
  logic             wrap_q;

  logic [WIDTH-1:0] cur_base;
  logic [WIDTH-1:0] cur_limit;
  logic [WIDTH-1:0] off_ext;
  logic [WIDTH-1:0] ptr_d;
  logic [WIDTH-1:0] addr_d;
  logic             wrap_d;
  mptr_op_e         op;

  assign off_ext = {{(WIDTH-OFFW){bus.offsetin[OFFW-1]}}, bus.offsetin};

`ifdef MPTR_CIRC_EN
  assign cur_base  = base_q[bus.sel];
  assign cur_limit = limit_q[bus.sel];
`else
  assign cur_base  = {WIDTH{MPTR_BASE_RST_BIT}};
  assign cur_limit = {WIDTH{MPTR_LIMIT_RST_BIT}};
`endif

  always_comb begin
    op = OP_NONE;
    if (bus.write)                op = OP_WRITE;
    else if (bus.writeu)          op = OP_WRITEU;
    else if (bus.write_mode)      op = OP_MODE;
`ifdef MPTR_CIRC_EN
    else if (bus.write_base)      op = OP_BASE;
    else if (bus.write_limit)     op = OP_LIMIT;
`endif
    else if (bus.read_abus)       op = OP_READ;
  end

  mptr_step #(.WIDTH(WIDTH)) u_step (
    .ptr_i   (ptr_q[bus.sel]),
    .off_i   (off_ext),
    .mode_i  (mode_q[bus.sel]),
    .base_i  (cur_base),
    .limit_i (cur_limit),
    .next_o  (ptr_d),
    .addr_o  (addr_d),
    .wrap_o  (wrap_d)
  );

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the pointer arrays are small flop banks with defined reset contents, not RAM, so they are reset.
      for (int i = 0; i < NPTR; i++) begin
        ptr_q[i]   <= {WIDTH{MPTR_PTR_RST_BIT}};
        mode_q[i]  <= MPTR_MODE_RST;
`ifdef MPTR_CIRC_EN
        base_q[i]  <= {WIDTH{MPTR_BASE_RST_BIT}};
        limit_q[i] <= {WIDTH{MPTR_LIMIT_RST_BIT}};
`endif
      end
      abus_q       <= '0;
      abus_valid_q <= 1'b0;
      dbus_q       <= '0;
      dbus_valid_q <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      abus_valid_q <= 1'b0;
      wrap_q       <= 1'b0;
      dbus_valid_q <= bus.read_dbus;
      if (bus.read_dbus) dbus_q <= ptr_q[bus.sel];

      case (op)
        OP_WRITE:  ptr_q[bus.sel]  <= bus.din;
        OP_WRITEU: ptr_q[bus.sel]  <= {bus.din[WIDTH-1:8], ptr_q[bus.sel][7:0]};
        OP_MODE:   mode_q[bus.sel] <= mptr_mode_e'(bus.din[1:0]);
`ifdef MPTR_CIRC_EN
        OP_BASE:   base_q[bus.sel]  <= bus.din;
        OP_LIMIT:  limit_q[bus.sel] <= bus.din;
`endif
        OP_READ: begin
          ptr_q[bus.sel] <= ptr_d;
          abus_q         <= addr_d;
          abus_valid_q   <= 1'b1;
          wrap_q         <= wrap_d;
        end
        default: ;
      endcase
    end
  end

  assign bus.abus_out   = abus_q;
  assign bus.abus_valid = abus_valid_q;
  assign bus.dbus_out   = dbus_q;
  assign bus.dbus_valid = dbus_valid_q;
  assign bus.wrap       = wrap_q;

endmodule

// File: tb/tb_mptr_bank.sv
// Directed self-checking bench for mptr_bank (default build; circular cases when MPTR_CIRC_EN is defined).
module tb_mptr_bank;

  localparam int WIDTH = 16;
  localparam int NPTR  = 4;
  localparam int OFFW  = 12;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  mptr_bank_if #(.WIDTH(WIDTH), .NPTR(NPTR), .OFFW(OFFW)) bus ();

  mptr_bank #(.WIDTH(WIDTH), .NPTR(NPTR), .OFFW(OFFW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic clr();
    bus.write      = 1'b0;
    bus.writeu     = 1'b0;
    bus.write_mode = 1'b0;
`ifdef MPTR_CIRC_EN
    bus.write_base  = 1'b0;
    bus.write_limit = 1'b0;
`endif
    bus.read_abus  = 1'b0;
    bus.read_dbus  = 1'b0;
  endtask

  // Advance one edge and sample 1 time unit later, away from the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int s, input logic [15:0] d);
    clr(); bus.sel = 2'(s); bus.din = d; bus.write = 1'b1; cyc();
  endtask

  task automatic do_mode(input int s, input logic [1:0] m);
    clr(); bus.sel = 2'(s); bus.din = {14'h0, m}; bus.write_mode = 1'b1; cyc();
  endtask

  task automatic do_read(input int s, input logic [11:0] off);
    clr(); bus.sel = 2'(s); bus.offsetin = off; bus.read_abus = 1'b1; cyc();
  endtask

  task automatic do_dbus(input int s);
    clr(); bus.sel = 2'(s); bus.read_dbus = 1'b1; cyc();
  endtask

  initial begin
    clr();
    bus.sel      = '0;
    bus.din      = '0;
    bus.offsetin = '0;
    reset        = 1'b1;
    cyc(); cyc();
    check("rst_abus",       32'(bus.abus_out),   32'h0);
    check("rst_abus_valid", 32'(bus.abus_valid), 32'h0);
    check("rst_dbus",       32'(bus.dbus_out),   32'h0);
    check("rst_dbus_valid", 32'(bus.dbus_valid), 32'h0);
    check("rst_wrap",       32'(bus.wrap),       32'h0);
    reset = 1'b0;

    for (int s = 0; s < NPTR; s++) begin
      do_dbus(s);
      check($sformatf("rst_ptr%0d", s), 32'(bus.dbus_out),   32'h0);
      check("rst_dbus_v",               32'(bus.dbus_valid), 32'h1);
    end
    clr(); cyc();
    check("dbus_v_pulse", 32'(bus.dbus_valid), 32'h0);

    // POST on ptr1
    do_write(1, 16'h0F0F);
    check("write_no_abus_v", 32'(bus.abus_valid), 32'h0);
    do_read(1, 12'h002);
    check("post1_abus",   32'(bus.abus_out),   32'h0F0F);
    check("post1_valid",  32'(bus.abus_valid), 32'h1);
    check("post1_wrap",   32'(bus.wrap),       32'h0);
    do_read(1, 12'h002);
    check("post2_abus",   32'(bus.abus_out),   32'h0F11);
    do_dbus(1);
    check("ptr1_0F13",    32'(bus.dbus_out),   32'h0F13);
    check("abus_v_pulse", 32'(bus.abus_valid), 32'h0);
    do_dbus(0);
    check("ptr0_held",    32'(bus.dbus_out),   32'h0000);

    // PRE on ptr2 with carry and borrow
    do_write(2, 16'hFFFE);
    do_mode(2, 2'b01);
    do_read(2, 12'h002);
    check("pre_carry_abus", 32'(bus.abus_out), 32'h0000);
    check("pre_carry_wrap", 32'(bus.wrap),     32'h1);
    do_read(2, 12'hFFF);
    check("pre_borrow_abus", 32'(bus.abus_out), 32'hFFFF);
    check("pre_borrow_wrap", 32'(bus.wrap),     32'h1);
    do_read(2, 12'h000);
    check("off0_abus", 32'(bus.abus_out), 32'hFFFF);
    check("off0_wrap", 32'(bus.wrap),     32'h0);
    do_read(2, 12'h7FF);
    check("pre_pos_big",  32'(bus.abus_out), 32'h07FE);
    check("pre_pos_wrap", 32'(bus.wrap),     32'h1);

    // writeu keeps low byte; read_dbus in the same cycle sees the old value
    clr(); bus.sel = 2'd1; bus.din = 16'h03AB; bus.writeu = 1'b1; bus.read_dbus = 1'b1; cyc();
    check("dbus_pre_update", 32'(bus.dbus_out), 32'h0F13);
    do_dbus(1);
    check("writeu_0313", 32'(bus.dbus_out), 32'h0313);

    // write beats read_abus
    clr(); bus.sel = 2'd1; bus.din = 16'h1234; bus.offsetin = 12'h001;
    bus.write = 1'b1; bus.read_abus = 1'b1; cyc();
    check("suppressed_abus_v", 32'(bus.abus_valid), 32'h0);
    do_dbus(1);
    check("write_wins", 32'(bus.dbus_out), 32'h1234);

    // writeu beats write_mode: pointer upper byte changes, mode stays POST
    clr(); bus.sel = 2'd1; bus.din = 16'h5601; bus.writeu = 1'b1; bus.write_mode = 1'b1; cyc();
    do_read(1, 12'h001);
    check("writeu_over_mode", 32'(bus.abus_out), 32'h5634);
    do_read(1, 12'h001);
    check("post_b2b", 32'(bus.abus_out), 32'h5635);

    // HOLD and reserved modes on ptr3
    do_write(3, 16'h0042);
    do_mode(3, 2'b10);
    do_read(3, 12'h005);
    check("hold1", 32'(bus.abus_out), 32'h0042);
    do_read(3, 12'h005);
    check("hold2", 32'(bus.abus_out), 32'h0042);
    do_mode(3, 2'b11);
    do_read(3, 12'hFFF);
    check("rsvd_abus", 32'(bus.abus_out), 32'h0042);
    check("rsvd_wrap", 32'(bus.wrap),     32'h0);

`ifdef MPTR_CIRC_EN
    clr(); bus.sel = 2'd0; bus.din = 16'h0100; bus.write_base  = 1'b1; cyc();
    clr(); bus.sel = 2'd0; bus.din = 16'h0103; bus.write_limit = 1'b1; cyc();
    do_write(0, 16'h0103);
    do_read(0, 12'h002);
    check("circ_abus", 32'(bus.abus_out), 32'h0103);
    check("circ_wrap", 32'(bus.wrap),     32'h1);
    do_dbus(0);
    check("circ_ptr_0101", 32'(bus.dbus_out), 32'h0101);
    do_read(0, 12'h008);
    check("circ_big_wrap", 32'(bus.wrap), 32'h1);
    do_dbus(0);
    check("circ_ptr_base", 32'(bus.dbus_out), 32'h0100);
    do_read(0, 12'h001);
    check("circ_inside_wrap", 32'(bus.wrap), 32'h0);
`endif

    // Reset with read_abus asserted wins
    do_read(1, 12'h001);
    clr(); bus.sel = 2'd1; bus.offsetin = 12'h001; bus.read_abus = 1'b1; bus.read_dbus = 1'b1;
    reset = 1'b1; cyc();
    check("rst_mid_abus",   32'(bus.abus_out),   32'h0);
    check("rst_mid_abus_v", 32'(bus.abus_valid), 32'h0);
    check("rst_mid_dbus_v", 32'(bus.dbus_valid), 32'h0);
    check("rst_mid_wrap",   32'(bus.wrap),       32'h0);
    reset = 1'b0;
    do_dbus(1);
    check("rst_mid_ptr1", 32'(bus.dbus_out), 32'h0);
    do_read(2, 12'h003);
    check("rst_mode_post", 32'(bus.abus_out), 32'h0);
    do_read(2, 12'h003);
    check("rst_mode_post2", 32'(bus.abus_out), 32'h3);

    clr(); cyc();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
